// File: rtl/tcp_route_lookup_arb.sv
// tcp_route_lookup_arb: round-robin arbiter sharing the conn-table TX route lookup among N_REQ requesters,
// with in-order tagging and per-requester credit-controlled response FIFOs. Optional stats: TCP_ROUTE_ARB_STATS_EN.
module tcp_route_lookup_arb #(
    parameter int N_REQ      = 4,
    parameter int SID_BITS   = 10,
    parameter int ROUTE_BITS = 14,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [N_REQ-1:0]            s_req_valid,
    output logic [N_REQ-1:0]            s_req_ready,
    input  logic [N_REQ*SID_BITS-1:0]   s_req_sid,
    output logic [N_REQ-1:0]            m_rsp_valid,
    input  logic [N_REQ-1:0]            m_rsp_ready,
    output logic [N_REQ*SID_BITS-1:0]   m_rsp_sid,
    output logic [N_REQ*ROUTE_BITS-1:0] m_rsp_route_id,
    output logic [SID_BITS-1:0]         tx_sid,
    output logic                        tx_sid_valid,
    input  logic [ROUTE_BITS-1:0]       tx_route_id,
    input  logic                        tx_route_id_valid,
    output logic                        err_orphan
`ifdef TCP_ROUTE_ARB_STATS_EN
   ,output logic [N_REQ*32-1:0]         stat_grants,
    output logic [31:0]                 stat_stall
`endif
);
    localparam int RRW = N_REQ > 1 ? $clog2(N_REQ) : 1;
    localparam int PW  = $clog2(RSP_DEPTH);
    localparam int CW  = PW + 1;
    localparam int TD  = N_REQ * RSP_DEPTH;
    localparam int TW  = $clog2(TD);
    localparam logic [CW-1:0] DEPTH_C = CW'(RSP_DEPTH);

    logic [RRW-1:0]        rr, gnt_idx;
    logic                  gnt;
    logic [N_REQ-1:0]      elig, rsp_push, rsp_pop;
    logic [CW-1:0]         fcnt [N_REQ];
    logic [CW-1:0]         infl [N_REQ];
    logic [PW-1:0]         wp [N_REQ];
    logic [PW-1:0]         rp [N_REQ];
    logic [SID_BITS-1:0]   rsid [N_REQ][RSP_DEPTH];
    logic [ROUTE_BITS-1:0] rroute [N_REQ][RSP_DEPTH];
    logic [RRW-1:0]        tg [TD];
    logic [SID_BITS-1:0]   ts [TD];
    logic [TW-1:0]         twp, trp;
    logic [TW:0]           tcnt;
    logic                  ret;
    logic [RRW-1:0]        ret_g;
    logic [SID_BITS-1:0]   ret_sid, gnt_sid;
    int                    j;

    // Credit uses start-of-cycle counts only, so a same-cycle pop never frees a slot for this grant
    always_comb begin
        for (int i = 0; i < N_REQ; i++)
            elig[i] = s_req_valid[i] && (fcnt[i] + infl[i] < DEPTH_C);
    end

    // Reverse scan so the eligible index closest to rr is the last one written
    always_comb begin
        gnt = 1'b0;
        gnt_idx = '0;
        j = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = int'(rr) + k;
            j = j >= N_REQ ? j - N_REQ : j;
            if (elig[j]) begin
                gnt = 1'b1;
                gnt_idx = RRW'(j);
            end
        end
    end

    assign s_req_ready = gnt ? (N_REQ'(1) << gnt_idx) : '0;
    assign gnt_sid     = s_req_sid[gnt_idx*SID_BITS +: SID_BITS];
    assign ret         = tx_route_id_valid && tcnt != '0;
    assign ret_g       = tg[trp];
    assign ret_sid     = ts[trp];

    always_comb begin
        m_rsp_valid = '0;
        m_rsp_sid = '0;
        m_rsp_route_id = '0;
        rsp_push = '0;
        rsp_pop = '0;
        for (int i = 0; i < N_REQ; i++) begin
            m_rsp_valid[i] = fcnt[i] != '0;
            m_rsp_sid[i*SID_BITS +: SID_BITS] = m_rsp_valid[i] ? rsid[i][rp[i]] : '0;
            m_rsp_route_id[i*ROUTE_BITS +: ROUTE_BITS] = m_rsp_valid[i] ? rroute[i][rp[i]] : '0;
            rsp_push[i] = ret && ret_g == RRW'(i);
            rsp_pop[i] = m_rsp_valid[i] && m_rsp_ready[i];
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rr <= '0;
            tx_sid <= '0;
            tx_sid_valid <= 1'b0;
            err_orphan <= 1'b0;
            twp <= '0;
            trp <= '0;
            tcnt <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                fcnt[i] <= '0;
                infl[i] <= '0;
                wp[i] <= '0;
                rp[i] <= '0;
            end
        end else begin
            tx_sid_valid <= gnt;
            if (gnt) begin
                tx_sid <= gnt_sid;
                rr <= gnt_idx == RRW'(N_REQ - 1) ? '0 : gnt_idx + 1'b1;
                twp <= twp == TW'(TD - 1) ? '0 : twp + 1'b1;
            end
            if (ret)
                trp <= trp == TW'(TD - 1) ? '0 : trp + 1'b1;
            tcnt <= tcnt + (TW+1)'(gnt) - (TW+1)'(ret);
            err_orphan <= err_orphan | (tx_route_id_valid && tcnt == '0);
            for (int i = 0; i < N_REQ; i++) begin
                infl[i] <= infl[i] + CW'(gnt && gnt_idx == RRW'(i)) - CW'(rsp_push[i]);
                fcnt[i] <= fcnt[i] + CW'(rsp_push[i]) - CW'(rsp_pop[i]);
                wp[i] <= wp[i] + PW'(rsp_push[i]);
                rp[i] <= rp[i] + PW'(rsp_pop[i]);
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (gnt) begin
            tg[twp] <= gnt_idx;
            ts[twp] <= gnt_sid;
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (rsp_push[i]) begin
                rsid[i][wp[i]] <= ret_sid;
                rroute[i][wp[i]] <= tx_route_id;
            end
        end
    end

`ifdef TCP_ROUTE_ARB_STATS_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            stat_grants <= '0;
            stat_stall <= '0;
        end else begin
            stat_stall <= stat_stall + 32'(|s_req_valid && !gnt);
            for (int i = 0; i < N_REQ; i++)
                if (gnt && gnt_idx == RRW'(i))
                    stat_grants[i*32 +: 32] <= stat_grants[i*32 +: 32] + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_tcp_route_lookup_arb.sv
// tb_tcp_route_lookup_arb: directed bench for tcp_route_lookup_arb with an L=1 in-order conn-table model.
module tb_tcp_route_lookup_arb;
    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic [3:0]  s_req_valid = '0;
    logic [3:0]  s_req_ready;
    logic [39:0] s_req_sid = '0;
    logic [3:0]  m_rsp_valid;
    logic [3:0]  m_rsp_ready = '0;
    logic [39:0] m_rsp_sid;
    logic [55:0] m_rsp_route_id;
    logic [9:0]  tx_sid;
    logic        tx_sid_valid;
    logic [13:0] tx_route_id;
    logic        tx_route_id_valid;
    logic        err_orphan;
    logic        tbl_v, inj_v = 1'b0;
    logic [13:0] tbl_r, inj_r = '0;
    int          pass = 0, total = 0;
`ifdef TCP_ROUTE_ARB_STATS_EN
    logic [127:0] stat_grants;
    logic [31:0]  stat_stall;
`endif

    tcp_route_lookup_arb dut (
        .aclk(clk), .aresetn(aresetn),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_sid(s_req_sid),
        .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready), .m_rsp_sid(m_rsp_sid),
        .m_rsp_route_id(m_rsp_route_id), .tx_sid(tx_sid), .tx_sid_valid(tx_sid_valid),
        .tx_route_id(tx_route_id), .tx_route_id_valid(tx_route_id_valid), .err_orphan(err_orphan)
`ifdef TCP_ROUTE_ARB_STATS_EN
       ,.stat_grants(stat_grants), .stat_stall(stat_stall)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] route_of(input logic [9:0] s);
        return 14'h1ABC + 14'(s) - 14'h15;
    endfunction

    // Connection table: fixed one-cycle in-order latency, plus an injection path for orphan results
    always @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            tbl_v <= 1'b0;
            tbl_r <= '0;
        end else begin
            tbl_v <= tx_sid_valid;
            tbl_r <= route_of(tx_sid);
        end
    end
    assign tx_route_id_valid = tbl_v | inj_v;
    assign tx_route_id = inj_v ? inj_r : tbl_r;

    task automatic do_reset;
        @(negedge clk);
        aresetn = 1'b0;
        s_req_valid = '0;
        m_rsp_ready = '0;
        repeat (2) @(negedge clk);
        aresetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        total++;
        if ({s_req_ready, m_rsp_valid, tx_sid_valid, tx_sid, err_orphan, m_rsp_sid, m_rsp_route_id} !== '0)
            $display("FAIL reset_outputs: got rdy=%b vld=%b txv=%b txsid=%h err=%b", s_req_ready, m_rsp_valid, tx_sid_valid, tx_sid, err_orphan);
        else pass++;
        aresetn = 1'b1;
        @(negedge clk);
        total++;
        if ({s_req_ready, m_rsp_valid, tx_sid_valid, err_orphan} !== '0)
            $display("FAIL reset_release_idle: got rdy=%b vld=%b txv=%b err=%b want all 0", s_req_ready, m_rsp_valid, tx_sid_valid, err_orphan);
        else pass++;
    endtask

    task automatic test_single;
        @(negedge clk);
        m_rsp_ready = 4'hF;
        s_req_sid[20 +: 10] = 10'h15;
        s_req_valid = 4'b0100;
        #1;
        total++;
        if (s_req_ready !== 4'b0100) $display("FAIL single_grant: got %b want 0100", s_req_ready); else pass++;
        @(negedge clk);
        s_req_valid = '0;
        total++;
        if ({tx_sid_valid, tx_sid} !== {1'b1, 10'h15}) $display("FAIL single_tx: got v=%b sid=%h want v=1 sid=015", tx_sid_valid, tx_sid); else pass++;
        total++;
        if (m_rsp_valid !== 4'b0000) $display("FAIL single_early_T1: got %b want 0000", m_rsp_valid); else pass++;
        @(negedge clk);
        total++;
        if ({m_rsp_valid, tx_sid_valid} !== 5'b0) $display("FAIL single_T2: got rsp=%b txv=%b want 0", m_rsp_valid, tx_sid_valid); else pass++;
        @(negedge clk);
        total++;
        if (m_rsp_valid !== 4'b0100) $display("FAIL single_rsp_valid: got %b want 0100", m_rsp_valid); else pass++;
        total++;
        if ({m_rsp_sid[20 +: 10], m_rsp_route_id[28 +: 14]} !== {10'h15, 14'h1ABC})
            $display("FAIL single_rsp_data: got sid=%h route=%h want 015/1abc", m_rsp_sid[20 +: 10], m_rsp_route_id[28 +: 14]);
        else pass++;
        @(negedge clk);
        total++;
        if (m_rsp_valid !== 4'b0000) $display("FAIL single_popped: got %b want 0000", m_rsp_valid); else pass++;
    endtask

    task automatic test_fairness;
        int got [4];
        logic [9:0] es;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            got[i] = 0;
            s_req_sid[i*10 +: 10] = 10'(256 + i);
        end
        m_rsp_ready = 4'hF;
        s_req_valid = 4'hF;
        for (int c = 0; c < 108; c++) begin
            if (c == 100) s_req_valid = '0;
            #1;
            if (c < 100) begin
                total++;
                if (s_req_ready !== 4'(1 << (c % 4))) $display("FAIL fair_order c=%0d: got %b want %b", c, s_req_ready, 4'(1 << (c % 4))); else pass++;
            end
            if (c > 0 && c <= 100) begin
                es = 10'(256 + (c - 1) % 4);
                total++;
                if ({tx_sid_valid, tx_sid} !== {1'b1, es}) $display("FAIL fair_tx c=%0d: got v=%b sid=%h want v=1 sid=%h", c, tx_sid_valid, tx_sid, es); else pass++;
            end
            for (int i = 0; i < 4; i++) begin
                if (m_rsp_valid[i]) begin
                    got[i]++;
                    es = 10'(256 + i);
                    total++;
                    if ({m_rsp_sid[i*10 +: 10], m_rsp_route_id[i*14 +: 14]} !== {es, route_of(es)})
                        $display("FAIL fair_rsp r%0d: got sid=%h route=%h want %h/%h", i, m_rsp_sid[i*10 +: 10], m_rsp_route_id[i*14 +: 14], es, route_of(es));
                    else pass++;
                end
            end
            @(negedge clk);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (got[i] !== 25) $display("FAIL fair_count r%0d: got %0d want 25", i, got[i]); else pass++;
        end
    endtask

    task automatic test_credit_stall;
        int n, g0, g3;
        do_reset();
        m_rsp_ready = 4'b1101;
        s_req_sid[10 +: 10] = 10'h2A;
        s_req_sid[0 +: 10] = 10'h031;
        s_req_sid[30 +: 10] = 10'h033;
        s_req_valid = 4'b0010;
        n = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            n += int'(s_req_ready[1]);
            if (c >= 4) begin
                total++;
                if (s_req_ready !== 4'b0000) $display("FAIL credit_block c=%0d: got %b want 0000", c, s_req_ready); else pass++;
            end
            @(negedge clk);
        end
        total++;
        if (n !== 4) $display("FAIL credit_grants: got %0d want 4", n); else pass++;
        total++;
        if (m_rsp_valid !== 4'b0010) $display("FAIL credit_rsp_held: got %b want 0010", m_rsp_valid); else pass++;
        s_req_valid = 4'b1011;
        g0 = 0;
        g3 = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            total++;
            if (s_req_ready[1] !== 1'b0) $display("FAIL credit_others_r1 c=%0d: got 1 want 0", c); else pass++;
            g0 += int'(s_req_ready[0]);
            g3 += int'(s_req_ready[3]);
            @(negedge clk);
        end
        total++;
        if ({g0, g3} !== {32'd2, 32'd2}) $display("FAIL credit_others: got g0=%0d g3=%0d want 2/2", g0, g3); else pass++;
        s_req_valid = 4'b0010;
        repeat (6) @(negedge clk);
        m_rsp_ready[1] = 1'b1;
        #1;
        total++;
        if ({m_rsp_sid[10 +: 10], m_rsp_route_id[14 +: 14]} !== {10'h2A, route_of(10'h2A)})
            $display("FAIL credit_rsp_data: got sid=%h route=%h want 02a/%h", m_rsp_sid[10 +: 10], m_rsp_route_id[14 +: 14], route_of(10'h2A));
        else pass++;
        @(negedge clk);
        m_rsp_ready[1] = 1'b0;
        n = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            n += int'(s_req_ready[1]);
            @(negedge clk);
        end
        total++;
        if (n !== 1) $display("FAIL credit_refill: got %0d grants want 1", n); else pass++;
        s_req_valid = '0;
    endtask

    task automatic test_back_to_back;
        logic [9:0] sb [$];
        logic [9:0] es;
        int sent = 0, recv = 0, cyc = 0;
        do_reset();
        while ((sent < 64 || sb.size() != 0) && cyc < 3000) begin
            s_req_valid = {3'b000, sent < 64 && $urandom_range(0, 3) != 0};
            s_req_sid[0 +: 10] = 10'($urandom);
            m_rsp_ready[0] = $urandom_range(0, 3) != 0;
            #1;
            if (s_req_ready[0]) begin
                sb.push_back(s_req_sid[0 +: 10]);
                sent++;
            end
            if (m_rsp_valid[0] && m_rsp_ready[0]) begin
                recv++;
                total++;
                if (sb.size() == 0) $display("FAIL b2b_unexpected: got sid=%h with no lookup pending", m_rsp_sid[0 +: 10]);
                else begin
                    es = sb.pop_front();
                    if ({m_rsp_sid[0 +: 10], m_rsp_route_id[0 +: 14]} !== {es, route_of(es)})
                        $display("FAIL b2b_order #%0d: got sid=%h route=%h want %h/%h", recv, m_rsp_sid[0 +: 10], m_rsp_route_id[0 +: 14], es, route_of(es));
                    else pass++;
                end
            end
            @(negedge clk);
            cyc++;
        end
        s_req_valid = '0;
        total++;
        if (recv !== 64 || sb.size() != 0) $display("FAIL b2b_complete: got %0d responses (%0d pending) want 64 (0)", recv, sb.size()); else pass++;
    endtask

    task automatic test_orphan;
        m_rsp_ready = 4'hF;
        repeat (2) @(negedge clk);
        total++;
        if (err_orphan !== 1'b0) $display("FAIL orphan_pre: got %b want 0", err_orphan); else pass++;
        inj_v = 1'b1;
        inj_r = 14'h3FFF;
        @(negedge clk);
        inj_v = 1'b0;
        total++;
        if (err_orphan !== 1'b1) $display("FAIL orphan_set: got %b want 1", err_orphan); else pass++;
        repeat (3) @(negedge clk);
        total++;
        if ({err_orphan, m_rsp_valid} !== 5'b10000) $display("FAIL orphan_held: got err=%b rsp=%b want 1/0000", err_orphan, m_rsp_valid); else pass++;
    endtask

    task automatic test_reset_mid;
        m_rsp_ready = '0;
        s_req_sid[0 +: 10] = 10'h011;
        s_req_sid[10 +: 10] = 10'h012;
        s_req_sid[20 +: 10] = 10'h013;
        s_req_sid[30 +: 10] = 10'h007;
        s_req_valid = 4'b0111;
        repeat (3) @(negedge clk);
        total++;
        if (m_rsp_valid !== 4'b0010) $display("FAIL mid_pre_rsp: got %b want 0010", m_rsp_valid); else pass++;
        aresetn = 1'b0;
        s_req_valid = '0;
        #1;
        total++;
        if ({s_req_ready, m_rsp_valid, tx_sid_valid, tx_sid, err_orphan, m_rsp_sid, m_rsp_route_id} !== '0)
            $display("FAIL mid_reset_zero: got rdy=%b vld=%b txv=%b txsid=%h err=%b", s_req_ready, m_rsp_valid, tx_sid_valid, tx_sid, err_orphan);
        else pass++;
        repeat (2) @(negedge clk);
        aresetn = 1'b1;
        m_rsp_ready = 4'hF;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++;
            if ({m_rsp_valid, tx_sid_valid} !== 5'b0) $display("FAIL mid_stale c=%0d: got rsp=%b txv=%b want 0", c, m_rsp_valid, tx_sid_valid); else pass++;
        end
        s_req_valid = 4'b1000;
        #1;
        total++;
        if (s_req_ready !== 4'b1000) $display("FAIL mid_new_grant: got %b want 1000", s_req_ready); else pass++;
        @(negedge clk);
        s_req_valid = '0;
        repeat (2) @(negedge clk);
        total++;
        if ({m_rsp_valid, m_rsp_sid[30 +: 10], m_rsp_route_id[42 +: 14]} !== {4'b1000, 10'h007, route_of(10'h007)})
            $display("FAIL mid_new_rsp: got vld=%b sid=%h route=%h want 1000/007/%h", m_rsp_valid, m_rsp_sid[30 +: 10], m_rsp_route_id[42 +: 14], route_of(10'h007));
        else pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_credit_stall();
        test_back_to_back();
        test_orphan();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
